// File: rtl/ras.sv
// Return address stack: circular stack of predicted return targets with a top
// pointer and a saturating occupancy counter, plus checkpoint restore.
// Ports:
//   clk, rst                     - clock, asynchronous active-high reset
//   push_valid, push_target      - push a return target (call predicted)
//   pop_valid                    - pop the top entry (return predicted)
//   restore_valid, restore_ptr,
//   restore_count                - restore a saved pointer/occupancy
//   top_target, top_valid        - entry at the top pointer, occupancy != 0
//   ras_ptr, ras_count           - current top pointer and occupancy
module ras #(
    parameter int unsigned RAS_ENTRIES      = 8,
    parameter int unsigned RAS_TARGET_WIDTH = 31,
    localparam int unsigned RAS_INDEX_WIDTH = $clog2(RAS_ENTRIES)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        push_valid,
    input  logic [RAS_TARGET_WIDTH-1:0] push_target,
    input  logic                        pop_valid,
    input  logic                        restore_valid,
    input  logic [RAS_INDEX_WIDTH-1:0]  restore_ptr,
    input  logic [RAS_INDEX_WIDTH:0]    restore_count,
    output logic [RAS_TARGET_WIDTH-1:0] top_target,
    output logic                        top_valid,
    output logic [RAS_INDEX_WIDTH-1:0]  ras_ptr,
    output logic [RAS_INDEX_WIDTH:0]    ras_count
);

    localparam int unsigned IW = RAS_INDEX_WIDTH;
    localparam int unsigned CW = RAS_INDEX_WIDTH + 1;
    localparam logic [CW-1:0] COUNT_FULL = CW'(RAS_ENTRIES);

    logic [RAS_TARGET_WIDTH-1:0] entries_q [RAS_ENTRIES];
    logic [RAS_TARGET_WIDTH-1:0] entries_d [RAS_ENTRIES];
    logic [IW-1:0]               ptr_q, ptr_d;
    logic [CW-1:0]               count_q, count_d;
    logic [IW-1:0]               ptr_inc;
    logic [IW-1:0]               ptr_dec;

    // Pointer arithmetic wraps naturally because the depth is a power of two.
    assign ptr_inc = ptr_q + IW'(1);
    assign ptr_dec = ptr_q - IW'(1);

    // Next-state: restore has priority, then replace-top, push, pop.
    always_comb begin
        ptr_d     = ptr_q;
        count_d   = count_q;
        entries_d = entries_q;
        if (restore_valid) begin
            ptr_d   = restore_ptr;
            count_d = (restore_count > COUNT_FULL) ? COUNT_FULL : restore_count;
        end else if (push_valid && pop_valid) begin
            entries_d[ptr_q] = push_target;
            if (count_q == '0) begin
                count_d = CW'(1);
            end
        end else if (push_valid) begin
            // When full, this overwrites the oldest entry.
            ptr_d              = ptr_inc;
            entries_d[ptr_inc] = push_target;
            if (count_q != COUNT_FULL) begin
                count_d = count_q + CW'(1);
            end
        end else if (pop_valid) begin
            // Underflow still moves the pointer so it tracks the call depth.
            ptr_d = ptr_dec;
            if (count_q != '0) begin
                count_d = count_q - CW'(1);
            end
        end
    end

    // State registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q   <= '0;
            count_q <= '0;
            for (int i = 0; i < int'(RAS_ENTRIES); i++) begin
                entries_q[i] <= '0;
            end
        end else begin
            ptr_q     <= ptr_d;
            count_q   <= count_d;
            entries_q <= entries_d;
        end
    end

    // Outputs come straight from registered state.
    assign top_target = entries_q[ptr_q];
    assign top_valid  = (count_q != '0);
    assign ras_ptr    = ptr_q;
    assign ras_count  = count_q;

endmodule

// File: tb/tb_ras.sv
// Self-checking bench for ras: a queue-free array model of the stack is
// updated from the stimulus and compared against the DUT every cycle, with
// literal expectations for the directed scenarios.
module tb_ras;

    localparam int N  = 8;
    localparam int W  = 31;
    localparam int IW = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          push_valid = 1'b0;
    logic [W-1:0]  push_target = '0;
    logic          pop_valid = 1'b0;
    logic          restore_valid = 1'b0;
    logic [IW-1:0] restore_ptr = '0;
    logic [IW:0]   restore_count = '0;
    logic [W-1:0]  top_target;
    logic          top_valid;
    logic [IW-1:0] ras_ptr;
    logic [IW:0]   ras_count;

    int checks = 0;
    int failures = 0;
    bit cmp_en = 1'b0;

    // Model state
    int m_e [N];
    int m_ptr = 0;
    int m_cnt = 0;

    ras #(.RAS_ENTRIES(N), .RAS_TARGET_WIDTH(W)) dut (
        .clk(clk), .rst(rst),
        .push_valid(push_valid), .push_target(push_target),
        .pop_valid(pop_valid),
        .restore_valid(restore_valid), .restore_ptr(restore_ptr),
        .restore_count(restore_count),
        .top_target(top_target), .top_valid(top_valid),
        .ras_ptr(ras_ptr), .ras_count(ras_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h @%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) m_e[i] = 0;
        m_ptr = 0;
        m_cnt = 0;
    endtask

    // Stack behaviour stated directly as integer arithmetic.
    task automatic model_apply(input bit pu, input int tg, input bit po,
                               input bit rv, input int rp, input int rc);
        if (rv) begin
            m_ptr = rp;
            m_cnt = (rc > N) ? N : rc;
        end else if (pu && po) begin
            m_e[m_ptr] = tg;
            if (m_cnt == 0) m_cnt = 1;
        end else if (pu) begin
            m_ptr = (m_ptr + 1) % N;
            m_e[m_ptr] = tg;
            m_cnt = (m_cnt == N) ? N : m_cnt + 1;
        end else if (po) begin
            m_ptr = (m_ptr + N - 1) % N;
            if (m_cnt > 0) m_cnt = m_cnt - 1;
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("model_top_target", 32'(top_target), 32'(m_e[m_ptr]));
            chk("model_top_valid",  32'(top_valid),  32'(m_cnt != 0));
            chk("model_ras_ptr",    32'(ras_ptr),    32'(m_ptr));
            chk("model_ras_count",  32'(ras_count),  32'(m_cnt));
        end
    end

    task automatic step(input bit pu, input int tg, input bit po,
                        input bit rv, input int rp, input int rc);
        push_valid    = pu;
        push_target   = W'(tg);
        pop_valid     = po;
        restore_valid = rv;
        restore_ptr   = IW'(rp);
        restore_count = (IW + 1)'(rc);
        @(posedge clk);
        model_apply(pu, tg, po, rv, rp, rc);
        @(negedge clk);
        #1;
    endtask

    task automatic push(input int tg);  step(1'b1, tg, 1'b0, 1'b0, 0, 0); endtask
    task automatic pop();               step(1'b0, 0, 1'b1, 1'b0, 0, 0);  endtask
    task automatic idle();              step(1'b0, 0, 1'b0, 1'b0, 0, 0);  endtask

    task automatic do_reset();
        rst = 1'b1;
        push_valid = 1'b0; pop_valid = 1'b0; restore_valid = 1'b0;
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
    endtask

    task automatic expect_state(input string tag, input int top, input int vld,
                                input int ptr, input int cnt);
        chk({tag, "_top"}, 32'(top_target), 32'(top));
        chk({tag, "_valid"}, 32'(top_valid), 32'(vld));
        chk({tag, "_ptr"}, 32'(ras_ptr), 32'(ptr));
        chk({tag, "_count"}, 32'(ras_count), 32'(cnt));
    endtask

    initial begin
        model_reset();
        do_reset();
        cmp_en = 1'b1;
        expect_state("reset", 0, 0, 0, 0);

        // Three consecutive pushes.
        push(32'h100); push(32'h200); push(32'h300);
        expect_state("push3", 32'h300, 1, 3, 3);

        // Replace-top with count 2 and top 0x200.
        pop();
        expect_state("pop_to_200", 32'h200, 1, 2, 2);
        step(1'b1, 32'h555, 1'b1, 1'b0, 0, 0);
        expect_state("replace_top", 32'h555, 1, 2, 2);

        // Checkpoint at ptr=2,count=2; speculate, then restore with push/pop also high.
        push(32'hA1); push(32'hA2); push(32'hA3); pop();
        expect_state("speculated", 32'hA2, 1, 4, 4);
        step(1'b1, 32'hBAD, 1'b1, 1'b1, 2, 2);
        expect_state("restored", 32'h555, 1, 2, 2);
        pop();
        expect_state("restored_entry1", 32'h100, 1, 1, 1);

        // Restore with an over-range count saturates at the depth.
        step(1'b0, 0, 1'b0, 1'b1, 5, 12);
        expect_state("restore_sat", 32'hA3, 1, 5, 8);
        idle();

        // Underflow from reset, then push.
        do_reset();
        pop();
        expect_state("underflow", 0, 0, 7, 0);
        push(32'hAB);
        expect_state("after_underflow", 32'hAB, 1, 0, 1);

        // Overflow: nine pushes, then pops down past empty.
        do_reset();
        for (int i = 1; i <= 9; i++) push(i);
        expect_state("overflow", 9, 1, 1, 8);
        for (int i = 0; i < 8; i++) begin
            chk("pop_seq_top", 32'(top_target), 32'(9 - i));
            pop();
        end
        pop();
        chk("ninth_pop_valid", 32'(top_valid), 32'd0);
        chk("ninth_pop_count", 32'(ras_count), 32'd0);

        // Asynchronous reset between edges during a push burst.
        do_reset();
        push(32'h11); push(32'h22);
        push_valid  = 1'b1;
        push_target = W'(32'h33);
        @(posedge clk);
        model_apply(1'b1, 32'h33, 1'b0, 1'b0, 0, 0);
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        expect_state("async_rst", 0, 0, 0, 0);
        push_target = W'(32'h44);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        push_valid = 1'b0;
        #1;
        expect_state("rst_held_push", 0, 0, 0, 0);
        idle();
        expect_state("post_rst_idle", 0, 0, 0, 0);
        push(32'h44);
        expect_state("post_rst_push", 32'h44, 1, 1, 1);

        // Mixed traffic checked by the per-cycle model compare.
        push(32'h7001); push(32'h7002); step(1'b1, 32'h7003, 1'b1, 1'b0, 0, 0);
        pop(); pop(); pop(); pop(); push(32'h7004); idle();

        cmp_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ras.md
RAS -- requirements
Module: ras

Interface
REQ-001 SHALL have parameter RAS_ENTRIES, default 8, stack depth; power of two, at least 2.
REQ-002 SHALL have parameter RAS_TARGET_WIDTH, default 31, return target width (PC[31:1]).
REQ-003 SHALL derive RAS_INDEX_WIDTH = $clog2(RAS_ENTRIES); it is not overridable.
REQ-004 CLK  input  1  single clock; all state updates on rising edge.
REQ-005 RST  input  1  asynchronous, active-high reset.
REQ-006 push_valid  input  1  a call is predicted this cycle; push push_target.
REQ-007 push_target  input  RAS_TARGET_WIDTH  return address to push.
REQ-008 pop_valid  input  1  a return is predicted this cycle; pop the top.
REQ-009 restore_valid  input  1  mispredict/checkpoint restore.
REQ-010 restore_ptr  input  RAS_INDEX_WIDTH  saved top pointer to restore.
REQ-011 restore_count  input  RAS_INDEX_WIDTH+1  saved occupancy to restore.
REQ-012 top_target  output  RAS_TARGET_WIDTH  entry at the current top pointer.
REQ-013 top_valid  output  1  high when count != 0.
REQ-014 ras_ptr  output  RAS_INDEX_WIDTH  current top pointer, for checkpointing.
REQ-015 ras_count  output  RAS_INDEX_WIDTH+1  current occupancy, 0..RAS_ENTRIES.

Function
REQ-016 SHALL hold RAS_ENTRIES target registers, a top pointer ptr and an occupancy counter count.
REQ-017 SHALL drive top_target, top_valid, ras_ptr and ras_count combinationally from registered state only, with no input-to-output path.
REQ-018 On push only: ptr <= ptr+1 mod RAS_ENTRIES; entry[ptr+1] <= push_target; count <= min(count+1, RAS_ENTRIES).
REQ-019 On push when count == RAS_ENTRIES: the oldest entry is overwritten (circular) and count stays at RAS_ENTRIES.
REQ-020 On pop only with count > 0: ptr <= ptr-1 mod RAS_ENTRIES; count <= count-1; entries are unchanged.
REQ-021 On pop only with count == 0 (underflow): ptr <= ptr-1 mod RAS_ENTRIES; count stays 0; entries are unchanged.
REQ-022 On push and pop in the same cycle (replace-top): entry[ptr] <= push_target; ptr is unchanged; count <= max(count, 1).
REQ-023 On restore_valid: ptr <= restore_ptr; count <= min(restore_count, RAS_ENTRIES); entries are unchanged.
REQ-024 When restore_valid is high, SHALL ignore push_valid and pop_valid that cycle.
REQ-025 With no valid input, state SHALL hold.
REQ-026 All updates SHALL be visible on outputs in the cycle after the triggering edge (1-cycle latency).
REQ-027 A new push/pop SHALL be accepted every cycle; there is no backpressure.

Reset
REQ-028 While RST is high, asynchronously: ptr = 0, count = 0, all entries = 0.
REQ-029 Hence after reset: top_target = 0, top_valid = 0, ras_ptr = 0, ras_count = 0.
REQ-030 RST asserted mid-operation SHALL discard all pending push/pop/restore with no partial update.

Verification
REQ-031 Reset then push 0x100, 0x200, 0x300 on consecutive cycles -> top_target=0x300, ras_ptr=3, ras_count=3, top_valid=1.
REQ-032 Push 9 targets 0x1..0x9 from reset, then pop 8 times -> tops read 0x9 down to 0x2; a 9th pop gives top_valid=0 and ras_count=0.
REQ-033 With count=2 and top 0x200, push 0x555 and pop in the same cycle -> top_target=0x555, ras_ptr unchanged, ras_count=2.
REQ-034 Record ras_ptr=2, ras_count=2; push 3 times and pop once; then restore_valid with push_valid=1 and pop_valid=1 -> ras_ptr=2, ras_count=2, entries 1..2 intact, push ignored.
REQ-035 From reset, pop_valid -> ras_ptr=7, ras_count=0, top_valid=0; then push 0xAB -> ras_ptr=0, ras_count=1, top_target=0xAB.
REQ-036 Assert RST asynchronously between edges during a push burst -> all outputs are 0 immediately and remain 0 until the first post-reset push.
